uart_tx_fifo_reader: RTL and testbench

Transmit-side consumer of the TX FIFO memory. It pops one word at a time from the FIFO read port and serialises it onto the UART line as start, data LSB-first, optional parity and stop bits. It sits between the TX FIFO read side and the tx pad, in the FIFO read clock domain. An internal baud counter divides rd_clk.

---
 rtl/uart_tx_fifo_reader.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_reader
// Function : Pops words from a show-ahead TX FIFO and serialises them as UART
//            frames (start, LSB-first data, optional parity, 1-2 stop bits).
// Revision : 1.0
// ============================================================================
module uart_tx_fifo_reader #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic             tx_enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_BIT_W  = $clog2(WIDTH + 1);

    localparam logic [c_BAUD_W-1:0] c_LAST_BAUD = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_LAST_DATA = c_BIT_W'(WIDTH - 1);
    localparam logic [c_BIT_W-1:0]  c_LAST_STOP = c_BIT_W'(STOP_BITS - 1);
    localparam logic                c_PAR_EN    = (PARITY_EN != 0);
    localparam logic                c_PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state_q,  w_state_d;
    logic [c_BAUD_W-1:0] r_baud_q,   w_baud_d;
    logic [c_BIT_W-1:0]  r_bit_q,    w_bit_d;
    logic [WIDTH-1:0]    r_shift_q,  w_shift_d;
    logic                r_parity_q, w_parity_d;
    logic                r_tx_q,     w_tx_d;
    logic                r_busy_q,   w_busy_d;
    logic                r_done_q,   w_done_d;

    logic w_bit_end;
    logic w_can_load;
    logic w_pop;
    logic w_load;

    assign w_bit_end  = (r_baud_q == c_LAST_BAUD);
    // A new word may be taken when idle or in the very last stop-bit cycle.
    assign w_can_load = (r_state_q == S_IDLE) ||
                        ((r_state_q == S_STOP) && w_bit_end && (r_bit_q == c_LAST_STOP));
    assign w_pop      = w_can_load && tx_enable && !fifo_empty && !rst;

    always_comb begin
        w_state_d  = r_state_q;
        w_baud_d   = r_baud_q + c_BAUD_W'(1);
        w_bit_d    = r_bit_q;
        w_shift_d  = r_shift_q;
        w_parity_d = r_parity_q;
        w_load     = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                w_baud_d = '0;
                w_load   = w_pop;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_d = S_DATA;
                    w_baud_d  = '0;
                    w_bit_d   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_d  = '0;
                    w_shift_d = r_shift_q >> 1;
                    if (r_bit_q == c_LAST_DATA) begin
                        w_bit_d   = '0;
                        w_state_d = c_PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_d = r_bit_q + c_BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_d = S_STOP;
                    w_baud_d  = '0;
                    w_bit_d   = '0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_d = '0;
                    if (r_bit_q == c_LAST_STOP) begin
                        w_bit_d   = '0;
                        w_state_d = S_IDLE;
                        w_load    = w_pop;
                    end else begin
                        w_bit_d = r_bit_q + c_BIT_W'(1);
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_baud_d  = '0;
                w_bit_d   = '0;
            end
        endcase

        if (w_load) begin
            w_state_d  = S_START;
            w_baud_d   = '0;
            w_bit_d    = '0;
            w_shift_d  = fifo_rdata;
            w_parity_d = (^fifo_rdata) ^ c_PAR_ODD;
        end

        // Outputs are registered copies of what the next state drives.
        case (w_state_d)
            S_START:  w_tx_d = 1'b0;
            S_DATA:   w_tx_d = w_shift_d[0];
            S_PARITY: w_tx_d = w_parity_d;
            default:  w_tx_d = 1'b1;
        endcase
        w_busy_d = (w_state_d != S_IDLE);
        w_done_d = (w_state_d == S_STOP) && (w_baud_d == c_LAST_BAUD) &&
                   (w_bit_d == c_LAST_STOP);
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_baud_q   <= '0;
            r_bit_q    <= '0;
            r_shift_q  <= '0;
            r_parity_q <= 1'b0;
            r_tx_q     <= 1'b1;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_baud_q   <= w_baud_d;
            r_bit_q    <= w_bit_d;
            r_shift_q  <= w_shift_d;
            r_parity_q <= w_parity_d;
            r_tx_q     <= w_tx_d;
            r_busy_q   <= w_busy_d;
            r_done_q   <= w_done_d;
        end
    end

    assign fifo_rd_en = w_pop;
    assign tx         = r_tx_q;
    assign busy       = r_busy_q;
    assign tx_done    = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_reader.sv
`default_nettype none
// Bench for uart_tx_fifo_reader: three parameter sets fed from bench-side FIFOs;
// every popped word becomes an expected frame compared cycle-by-cycle on the line.
module tb_uart_tx_fifo_reader;
    localparam int N   = 3;
    localparam int CPB = 4;
    localparam int W   = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         tx_enable;
    logic [N-1:0] fifo_empty, fifo_rd_en, tx, busy, tx_done;
    logic [W-1:0] fifo_rdata [N];

    logic [W-1:0] fq [N][$];
    int           pops [N];
    int           pushes [N];
    bit           do_pop [N];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Lane 0: no parity, 1 stop. Lane 1: even parity, 1 stop. Lane 2: odd parity, 2 stop.
    function automatic int par_en(input int g);    return (g == 0) ? 0 : 1; endfunction
    function automatic int par_odd(input int g);   return (g == 2) ? 1 : 0; endfunction
    function automatic int stop_bits(input int g); return (g == 2) ? 2 : 1; endfunction
    function automatic int frame_len(input int g);
        return (1 + W + par_en(g) + stop_bits(g)) * CPB;
    endfunction

    function automatic logic exp_line(input int g, input logic [W-1:0] d, input int k);
        int   b;
        logic odd;
        b   = k / CPB;
        odd = (par_odd(g) != 0);
        if (b == 0) return 1'b0;
        if (b <= W) return d[b-1];
        if (par_en(g) != 0 && b == W + 1) return (^d) ^ odd;
        return 1'b1;
    endfunction

    task automatic check(input bit ok, input string name, input int g, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s lane%0d cycle %0d: got %0d, expected %0d", name, g, cyc, act, exp);
    endtask

    task automatic refresh();
        for (int g = 0; g < N; g++) begin
            fifo_empty[g] = (fq[g].size() == 0);
            fifo_rdata[g] = (fq[g].size() == 0) ? W'($urandom) : fq[g][0];
        end
    endtask

    task automatic push(input int g, input logic [W-1:0] v);
        fq[g].push_back(v);
        pushes[g]++;
        refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n;
        bit done;
        n    = 0;
        done = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            done = (fifo_rd_en == '0) && (busy == '0) &&
                   (fq[0].size() == 0) && (fq[1].size() == 0) && (fq[2].size() == 0);
            n++;
        end
        check(done, name, 0, n, 4000);
        tick();
    endtask

    // FIFO model: a pop seen in a cycle removes the head just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < N; g++) begin
                if (do_pop[g]) begin
                    if (fq[g].size() > 0) void'(fq[g].pop_front());
                    do_pop[g] = 1'b0;
                end
            end
            refresh();
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [W-1:0] exp_d [$];
        int           exp_c [$];

        uart_tx_fifo_reader #(
            .WIDTH       (W),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   ((g == 0) ? 0 : 1),
            .PARITY_ODD  ((g == 2) ? 1 : 0),
            .STOP_BITS   ((g == 2) ? 2 : 1)
        ) u_dut (
            .rd_clk    (clk),
            .rst       (rst),
            .tx_enable (tx_enable),
            .fifo_empty(fifo_empty[g]),
            .fifo_rdata(fifo_rdata[g]),
            .fifo_rd_en(fifo_rd_en[g]),
            .tx        (tx[g]),
            .busy      (busy[g]),
            .tx_done   (tx_done[g])
        );

        // Scoreboard producer: each pop queues the frame the line must carry.
        initial begin
            forever begin
                @(negedge clk);
                if (fifo_rd_en[g] === 1'b1) begin
                    check(!fifo_empty[g] && !rst, "pop_legal", g,
                          int'({fifo_empty[g], rst}), 0);
                    if (busy[g] === 1'b1)
                        check(tx_done[g] === 1'b1, "b2b_pop_with_done", g, int'(tx_done[g]), 1);
                    exp_d.push_back(fifo_rdata[g]);
                    exp_c.push_back(cyc);
                    pops[g]++;
                    do_pop[g] = 1'b1;
                end
            end
        end

        // Line monitor: a falling tx starts a frame, checked against the queue head.
        initial begin
            bit           in_frame;
            bit           post;
            int           k;
            int           errs;
            int           bad_k;
            int           flen;
            int           pc;
            logic [W-1:0] d;
            in_frame = 0;
            post     = 0;
            k        = 0;
            errs     = 0;
            bad_k    = 0;
            d        = '0;
            flen     = frame_len(g);
            forever begin
                @(negedge clk);
                if (rst === 1'b1) begin
                    in_frame = 0;
                    post     = 0;
                end else begin
                    if (!in_frame) begin
                        if (post && tx[g] === 1'b1)
                            check(busy[g] === 1'b0, "busy_after_frame", g, int'(busy[g]), 0);
                        post = 0;
                        if (tx[g] === 1'b0) begin
                            check(exp_d.size() > 0, "start_has_pop", g, exp_d.size(), 1);
                            if (exp_d.size() > 0) begin
                                d  = exp_d.pop_front();
                                pc = exp_c.pop_front();
                                check(cyc == pc + 1, "pop_to_start", g, cyc - pc, 1);
                            end
                            in_frame = 1;
                            k        = 0;
                            errs     = 0;
                        end
                    end
                    if (in_frame) begin
                        if (tx[g] !== exp_line(g, d, k) || busy[g] !== 1'b1 ||
                            tx_done[g] !== (k == flen - 1)) begin
                            if (errs == 0) bad_k = k;
                            errs++;
                        end
                        k++;
                        if (k == flen) begin
                            check(errs == 0, $sformatf("frame_0x%02h(first bad cycle %0d)", d, bad_k),
                                  g, errs, 0);
                            in_frame = 0;
                            post     = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0 [N];
        int bad [N];
        rst       = 1'b1;
        tx_enable = 1'b0;
        refresh();
        repeat (3) tick();
        @(negedge clk);
        for (int g = 0; g < N; g++)
            check(tx[g] === 1'b1 && busy[g] === 1'b0 && fifo_rd_en[g] === 1'b0 && tx_done[g] === 1'b0,
                  "reset_state", g, int'({tx[g], busy[g], fifo_rd_en[g], tx_done[g]}), 8);
        tick();
        rst = 1'b0;
        tick();

        // Single 0xA5 frame on every lane.
        for (int g = 0; g < N; g++) push(g, 8'hA5);
        tx_enable = 1'b1;
        wait_idle("drain_a5");

        // 0x00 then 0xFF back-to-back.
        for (int g = 0; g < N; g++) begin
            push(g, 8'h00);
            push(g, 8'hFF);
        end
        wait_idle("drain_b2b");

        // Randomised traffic with tx_enable chattering.
        for (int i = 0; i < 600; i++) begin
            tx_enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) push(int'($urandom_range(0, N - 1)), W'($urandom));
            tick();
        end
        tx_enable = 1'b1;
        wait_idle("drain_random");

        // Empty FIFO with tx_enable high: line stays idle, then pop as soon as data appears.
        for (int g = 0; g < N; g++) bad[g] = 0;
        repeat (100) begin
            @(negedge clk);
            for (int g = 0; g < N; g++)
                if (fifo_rd_en[g] !== 1'b0 || tx[g] !== 1'b1 || busy[g] !== 1'b0) bad[g]++;
        end
        for (int g = 0; g < N; g++) check(bad[g] == 0, "idle_when_empty", g, bad[g], 0);
        tick();
        for (int g = 0; g < N; g++) push(g, W'($urandom));
        @(negedge clk);
        for (int g = 0; g < N; g++)
            check(fifo_rd_en[g] === 1'b1, "pop_same_cycle", g, int'(fifo_rd_en[g]), 1);
        tick();
        wait_idle("drain_empty_test");

        // tx_enable dropped during data bits with three words queued.
        tx_enable = 1'b0;
        for (int g = 0; g < N; g++) begin
            repeat (3) push(g, W'($urandom));
            p0[g] = pops[g];
        end
        tick();
        tx_enable = 1'b1;
        tick();
        repeat (20) tick();
        tx_enable = 1'b0;
        repeat (100) tick();
        for (int g = 0; g < N; g++) begin
            check(pops[g] - p0[g] == 1, "one_pop_after_disable", g, pops[g] - p0[g], 1);
            check(fq[g].size() == 2, "words_left", g, fq[g].size(), 2);
        end
        tx_enable = 1'b1;
        wait_idle("drain_disable");

        // Reset pulse mid-frame, then a fresh frame from the queued word.
        for (int g = 0; g < N; g++) begin
            p0[g] = pops[g];
            push(g, W'($urandom));
            push(g, W'($urandom));
        end
        tick();
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            check(tx[g] === 1'b1 && busy[g] === 1'b0 && tx_done[g] === 1'b0, "after_mid_reset", g,
                  int'({tx[g], busy[g], tx_done[g]}), 4);
            check(fifo_rd_en[g] === 1'b1, "pop_after_reset", g, int'(fifo_rd_en[g]), 1);
        end
        tick();
        wait_idle("drain_reset");
        for (int g = 0; g < N; g++)
            check(pops[g] - p0[g] == 2, "pops_around_reset", g, pops[g] - p0[g], 2);

        repeat (5) tick();
        for (int g = 0; g < N; g++)
            check(pops[g] == pushes[g], "pops_equal_pushes", g, pops[g], pushes[g]);
        check(g_lane[0].exp_d.size() == 0, "unsent_frames", 0, g_lane[0].exp_d.size(), 0);
        check(g_lane[1].exp_d.size() == 0, "unsent_frames", 1, g_lane[1].exp_d.size(), 0);
        check(g_lane[2].exp_d.size() == 0, "unsent_frames", 2, g_lane[2].exp_d.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
